// File: rtl/mem_fifo_streamer.sv
// Location-table -> data-memory -> per-channel FIFO streamer with back-pressure; never drops words.
// Optional UNDERFLOW_ERR_EN adds sticky err_underflow flags for pops of empty FIFOs.

module msf_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic [CW-1:0]     count
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr, rptr;
    logic              do_push, do_pop;

    assign empty   = count == '0;
    assign full    = count == CW'(DEPTH);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop) begin
                rptr    <= rptr + AW'(1);
                rd_data <= mem[rptr];
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst) mem[wptr] <= wdata;
    end
endmodule

module mem_fifo_streamer #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 8,
    parameter int LOC_AW     = 6,
    parameter int SEQ_LEN    = 45,
    parameter int ROW        = 5,
    parameter int NUM_CH     = 5,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_address,
    output logic                     busy,
    output logic                     done,
    output logic [LOC_AW-1:0]        loc_addr,
    input  logic [7:0]               loc_data,
    output logic                     mem_rd_en,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic [NUM_CH-1:0]        rd_en,
    output logic [NUM_CH*DATA_W-1:0] rd_data,
    output logic [NUM_CH-1:0]        empty,
    output logic [NUM_CH-1:0]        full
`ifdef UNDERFLOW_ERR_EN
    ,
    output logic [NUM_CH-1:0]        err_underflow
`endif
);
    localparam int STAGES = 2;
    localparam int CHW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t                        state, state_nxt;
    logic [LOC_AW-1:0]             idx;
    logic [CHW-1:0]                ch_s0;
    logic [ADDR_W-1:0]             base_q;
    logic [STAGES-1:0]             vld_pipe;
    logic [STAGES-1:0][CHW-1:0]    ch_pipe;
    logic                          pad_s2;
    logic [NUM_CH-1:0][CW-1:0]     cnt;
    logic [CW:0]                   occ;
    logic                          issue, last;
    logic [NUM_CH-1:0]             push;
    logic [DATA_W-1:0]             wdata;

    // Occupancy of the target channel includes words still in the pipeline,
    // so every issued element is guaranteed a slot when it arrives.
    always_comb begin
        occ = {1'b0, cnt[ch_s0]};
        for (int s = 0; s < STAGES; s++)
            if (vld_pipe[s] && ch_pipe[s] == ch_s0) occ = occ + (CW+1)'(1);
    end

    assign last  = idx == LOC_AW'(SEQ_LEN - 1);
    assign issue = (state == FETCH) && (occ < (CW+1)'(FIFO_DEPTH));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FETCH;
            FETCH:   if (issue && last) state_nxt = DRAIN;
            DRAIN:   if (vld_pipe == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy     = state != IDLE;
    assign done     = state == DONE;
    assign loc_addr = idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            ch_s0    <= '0;
            base_q   <= '0;
            vld_pipe <= '0;
            ch_pipe  <= '0;
            pad_s2   <= 1'b0;
        end else begin
            state    <= state_nxt;
            vld_pipe <= {vld_pipe[STAGES-2:0], issue};
            ch_pipe  <= {ch_pipe[STAGES-2:0], ch_s0};
            pad_s2   <= vld_pipe[0] && loc_data == 8'hFF;
            if (state == IDLE && start) begin
                base_q <= base_address;
                idx    <= '0;
                ch_s0  <= '0;
            end else if (issue) begin
                if (!last) idx <= idx + LOC_AW'(1);
                ch_s0 <= (ch_s0 == CHW'(NUM_CH - 1)) ? '0 : ch_s0 + CHW'(1);
            end
        end
    end

    // S1: table entry {row,col} becomes a memory address; pad entries skip the read.
    assign mem_rd_en = vld_pipe[0] && loc_data != 8'hFF;
    assign mem_addr  = mem_rd_en ? base_q + ADDR_W'(loc_data[7:4]) * ADDR_W'(ROW)
                                   + ADDR_W'(loc_data[3:0]) : '0;

    assign wdata = pad_s2 ? '0 : mem_rdata;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign push[c] = vld_pipe[STAGES-1] && ch_pipe[STAGES-1] == CHW'(c);
        msf_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk    (clk),
            .rst    (rst),
            .push   (push[c]),
            .wdata  (wdata),
            .pop    (rd_en[c]),
            .rd_data(rd_data[c*DATA_W +: DATA_W]),
            .empty  (empty[c]),
            .full   (full[c]),
            .count  (cnt[c])
        );
    end

`ifdef UNDERFLOW_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) err_underflow <= '0;
        else     err_underflow <= err_underflow | (rd_en & empty);
    end
`endif
endmodule

// File: tb/tb_mem_fifo_streamer.sv
// Scoreboard bench for mem_fifo_streamer: small FIFOs to exercise stalls, directed passes and resets.
module tb_mem_fifo_streamer;
    localparam int DATA_W = 32, ADDR_W = 8, LOC_AW = 6, SEQ_LEN = 45;
    localparam int ROW = 5, NUM_CH = 5, FIFO_DEPTH = 4;

    logic                     clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [ADDR_W-1:0]        base_address = '0;
    logic                     busy, done, mem_rd_en;
    logic [LOC_AW-1:0]        loc_addr;
    logic [7:0]               loc_data = '0;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_rdata = '0;
    logic [NUM_CH-1:0]        rd_en = '0;
    logic [NUM_CH*DATA_W-1:0] rd_data;
    logic [NUM_CH-1:0]        empty, full;
`ifdef UNDERFLOW_ERR_EN
    logic [NUM_CH-1:0]        err_underflow;
`endif

    mem_fifo_streamer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LOC_AW(LOC_AW), .SEQ_LEN(SEQ_LEN),
        .ROW(ROW), .NUM_CH(NUM_CH), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_address(base_address),
        .busy(busy), .done(done), .loc_addr(loc_addr), .loc_data(loc_data),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full)
`ifdef UNDERFLOW_ERR_EN
        , .err_underflow(err_underflow)
`endif
    );

    always #5 clk = ~clk;

    logic [7:0] loc_tab [64];
    always @(posedge clk) loc_data <= loc_tab[loc_addr];
    always @(posedge clk) if (mem_rd_en) mem_rdata <= 32'(mem_addr);

    int n_cmp = 0, n_bad = 0, n_rd = 0, n_done = 0;
    logic [DATA_W-1:0] exp_q [NUM_CH][$];
    logic [ADDR_W-1:0] addr_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: captures the pre-edge handshake, compares results just after the edge.
    always @(posedge clk) begin : mon
        logic [NUM_CH-1:0] pop_s;
        logic              rst_s, rd_s, d_s;
        logic [ADDR_W-1:0] a_s;
        pop_s = rd_en & ~empty;
        rst_s = rst; rd_s = mem_rd_en; a_s = mem_addr; d_s = done;
        #1;
        if (!rst_s) begin
            if (d_s) n_done++;
            if (rd_s) begin
                n_rd++;
                if (addr_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL mem_addr: got read of %0h with none expected", a_s);
                end else chk("mem_addr", 32'(a_s), 32'(addr_q.pop_front()));
            end
            for (int c = 0; c < NUM_CH; c++) if (pop_s[c]) begin
                if (exp_q[c].size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL pop_ch%0d: got %0h with no word expected", c, rd_data[c*DATA_W +: DATA_W]);
                end else chk($sformatf("rd_data_ch%0d", c), rd_data[c*DATA_W +: DATA_W], exp_q[c].pop_front());
            end
        end
    end

    task automatic load_pass(input logic [7:0] base);
        logic [7:0] e, a;
        for (int k = 0; k < SEQ_LEN; k++) begin
            e = loc_tab[k];
            if (e == 8'hFF) exp_q[k % NUM_CH].push_back('0);
            else begin
                a = base + 8'(e[7:4]) * 8'(ROW) + 8'(e[3:0]);
                addr_q.push_back(a);
                exp_q[k % NUM_CH].push_back(32'(a));
            end
        end
    endtask

    task automatic start_pass(input string name, input logic [7:0] base);
        load_pass(base);
        @(negedge clk); base_address = base; start = 1'b1;
        @(negedge clk); start = 1'b0; base_address = 8'h55;
        chk({name, "_busy"}, 32'(busy), 1);
        chk({name, "_idx0"}, 32'(loc_addr), 0);
    endtask

    // Entered at the first negedge after start was accepted (cycle 1).
    task automatic wait_done(input string name, input int exp_n);
        int n = 1;
        while (!done && n < 400) begin @(negedge clk); n++; end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: got no done within %0d cycles required one", name, n);
        end else begin
            if (exp_n > 0) chk({name, "_latency"}, n, exp_n);
            @(negedge clk);
            chk({name, "_done_pulse"}, 32'(done), 0);
            chk({name, "_busy_off"}, 32'(busy), 0);
        end
    endtask

    task automatic chk_drained(input string name);
        int tot = addr_q.size();
        for (int c = 0; c < NUM_CH; c++) tot += exp_q[c].size();
        chk(name, tot, 0);
    endtask

    initial begin
        int n, d0;
        for (int k = 0; k < 64; k++)
            loc_tab[k] = (k < SEQ_LEN) ? {4'(k / 5), 4'(k % 5)} : 8'hFF;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_mem_rd_en", 32'(mem_rd_en), 0);
        chk("rst_loc_addr", 32'(loc_addr), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_rd_data", 32'(|rd_data), 0);
        chk("rst_empty", 32'(empty), 32'h1f);
        chk("rst_full", 32'(full), 0);
        rst = 1'b0;
        @(negedge clk);

        // T1: continuous draining, base 0, no stalls
        rd_en = '1; n_rd = 0;
        start_pass("t1", 8'h00);
        wait_done("t1", 49);
        repeat (3) @(negedge clk);
        chk("t1_reads", n_rd, 45);
        chk_drained("t1_drained");

        // T2: pad entries, base that wraps the address space
        loc_tab[3] = 8'hFF; loc_tab[7] = 8'hFF; n_rd = 0;
        start_pass("t2", 8'hF0);
        wait_done("t2", 49);
        repeat (3) @(negedge clk);
        chk("t2_reads", n_rd, 43);
        chk_drained("t2_drained");
        loc_tab[3] = 8'h03; loc_tab[7] = 8'h12;

        // T3: no reads, stream stalls once every FIFO is full
        rd_en = '0; d0 = n_done;
        start_pass("t3", 8'h00);
        repeat (60) @(negedge clk);
        chk("t3_busy", 32'(busy), 1);
        chk("t3_full", 32'(full), 32'h1f);
        chk("t3_stall_idx", 32'(loc_addr), 20);
        chk("t3_no_done", n_done - d0, 0);
        rd_en = 5'b00001; @(negedge clk); rd_en = '0;
        repeat (5) @(negedge clk);
        chk("t3_one_more_idx", 32'(loc_addr), 21);
        chk("t3_full_again", 32'(full), 32'h1f);

        // T4: pop ch1, then pop again in the very cycle idx 21 is pushed
        rd_en = 5'b00010; @(negedge clk); rd_en = '0;
        @(negedge clk);
        @(negedge clk); rd_en = 5'b00010;
        @(negedge clk); rd_en = '0;
        chk("t4_push_pop_full", 32'(full), 32'h1d);
        chk("t4_idx", 32'(loc_addr), 22);
        rd_en = '1;
        wait_done("t4", 0);
        repeat (3) @(negedge clk);
        chk_drained("t4_drained");

        // T5: reset mid-pass, then a clean pass from idx 0
        start_pass("t5a", 8'h00);
        n = 0;
        while (loc_addr != 12 && n < 100) begin @(negedge clk); n++; end
        chk("t5_reach_idx12", 32'(loc_addr), 12);
        rst = 1'b1; d0 = n_done;
        @(negedge clk); rst = 1'b0;
        chk("t5_busy", 32'(busy), 0);
        chk("t5_empty", 32'(empty), 32'h1f);
        chk("t5_full", 32'(full), 0);
        chk("t5_loc_addr", 32'(loc_addr), 0);
        for (int c = 0; c < NUM_CH; c++) exp_q[c].delete();
        addr_q.delete();
        repeat (10) @(negedge clk);
        chk("t5_no_done", n_done - d0, 0);
        start_pass("t5b", 8'h00);
        wait_done("t5b", 49);
        repeat (3) @(negedge clk);
        chk_drained("t5_drained");

        // T6: pop of an empty FIFO leaves rd_data at the last popped word (idx 41)
        rd_en = 5'b00010;
        repeat (2) @(negedge clk);
        chk("t6_empty1", 32'(empty[1]), 1);
        chk("t6_rd_data_hold", rd_data[DATA_W +: DATA_W], 41);
        rd_en = '0;
`ifdef UNDERFLOW_ERR_EN
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        chk("t6_err_rst", 32'(err_underflow), 0);
        rd_en = 5'b00010; @(negedge clk); rd_en = '0;
        repeat (3) @(negedge clk);
        chk("t6_err_sticky", 32'(err_underflow), 32'h02);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        chk("t6_err_clear", 32'(err_underflow), 0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
